// File: rtl/cram_pkg.sv
// Shared types and default geometry for the CRAM configuration chain.
// The loader and the cell array top both take their default sizes from here.
package cram_pkg;

  localparam int CRAM_WORD_WIDTH = 8;
  localparam int CRAM_CHAIN_LEN  = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } cram_ld_state_t;

  // Number of bitstream words needed to fill a chain of the given length.
  function automatic int words_per_chain(input int chain_len, input int word_width);
    return (chain_len + word_width - 1) / word_width;
  endfunction

endpackage

// File: rtl/cram_word_serializer.sv
// Word-to-bit serializer for the CRAM loader: holds one bitstream word and
// presents it LSB first, flagging the word's last bit so the FSM can refetch without a gap.
module cram_word_serializer
  import cram_pkg::*;
#(
  parameter int WORD_WIDTH = CRAM_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  output logic                  bit_o,
  output logic                  word_empty_o
);

  localparam int LEFT_W = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] shreg_q;
  logic [LEFT_W-1:0]     left_q;

  // NOTE: the data shift register needs no reset; its bits are only observed after a load.
  always_ff @(posedge clk) begin
    if (load_i) begin
      shreg_q <= data_i;
    end else if (shift_i) begin
      shreg_q <= shreg_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      left_q <= '0;
    end else if (load_i) begin
      left_q <= LEFT_W'(WORD_WIDTH);
    end else if (shift_i && (left_q != '0)) begin
      left_q <= left_q - LEFT_W'(1);
    end
  end

  assign bit_o        = shreg_q[0];
  // High while the presented bit is the word's last one: the word is empty after this shift.
  assign word_empty_o = (left_q <= LEFT_W'(1));

endmodule

// File: rtl/cram_loader.sv
// Master of the CRAM configuration chain: streams bitstream words onto the chain head
// and stops after exactly CHAIN_LEN shifts. Define CRAM_READBACK_EN to add the readback comparator.
module cram_loader
  import cram_pkg::*;
#(
  parameter  int WORD_WIDTH = CRAM_WORD_WIDTH,
  parameter  int CHAIN_LEN  = CRAM_CHAIN_LEN,
  localparam int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  verify,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  cram_data_out,
  output logic                  cram_en,
  input  logic                  cram_data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_W-1:0]      bit_count
);

  cram_ld_state_t   state_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] bit_count_q;
  logic [CNT_W-1:0] bit_count_d;
  logic             take_word;
  logic             shift_now;
  logic             chain_full;
  logic             ser_bit;
  logic             ser_last;

  assign word_ready  = (state_q == FETCH) && en;
  assign take_word   = word_ready && word_valid;
  assign shift_now   = (state_q == SHIFT) && en;
  assign bit_count_d = bit_count_q + CNT_W'(1);
  assign chain_full  = (bit_count_d == CNT_W'(CHAIN_LEN));

  cram_word_serializer #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_serializer (
    .clk          (clk),
    .nrst         (nrst),
    .load_i       (take_word),
    .shift_i      (shift_now),
    .data_i       (word_data),
    .bit_o        (ser_bit),
    .word_empty_o (ser_last)
  );

  // NOTE: sequential state uses <= so every register here sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bit_count_q <= '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bit_count_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          if (take_word) begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bit_count_q <= bit_count_d;
          // Chain completion wins over word exhaustion, so no word is fetched past the end.
          if (chain_full) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else if (ser_last) begin
            state_q <= FETCH;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cram_en       = shift_now;
  assign cram_data_out = shift_now & ser_bit;
  assign busy          = busy_q;
  assign done          = done_q & en;
  assign bit_count     = bit_count_q;

`ifdef CRAM_READBACK_EN
  logic verify_q;
  logic error_q;

  // The chain is a FIFO of CHAIN_LEN bits, so the tail returns the previous pass bit for bit.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      verify_q <= 1'b0;
      error_q  <= 1'b0;
    end else if (en) begin
      if ((state_q == IDLE) && start) begin
        verify_q <= verify;
        error_q  <= 1'b0;
      end else if (shift_now && verify_q && (cram_data_in != ser_bit)) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error = error_q;
`else
  logic unused_readback;

  assign unused_readback = verify ^ cram_data_in;
  assign error           = 1'b0;
`endif

endmodule
